// File: rtl/multicycle_control.sv
// Multicycle control FSM for an RV32 subset (R-type, addi, ld, sd, beq/bge).
// Optional retired-instruction counter enabled by the CTRL_RETIRE_COUNT_EN macro.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        negative,
    output logic        instr_ready,
    output logic [1:0]  ALUOp,
    output logic [3:0]  Funct,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        branch_taken,
    output logic        done,
    output logic        illegal,
    output logic [31:0] retired_count,
    output logic [2:0]  state_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_SD     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [2:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;

    logic is_rtype, is_addi, is_ld, is_sd, is_branch, is_beq, is_bge, is_legal;
    logic unused_instr_bits;

    // Every control below decodes the latched word, never the live port.
    assign is_rtype  = (instr_q[6:0] == OP_RTYPE);
    assign is_addi   = (instr_q[6:0] == OP_ADDI);
    assign is_ld     = (instr_q[6:0] == OP_LD);
    assign is_sd     = (instr_q[6:0] == OP_SD);
    assign is_branch = (instr_q[6:0] == OP_BRANCH);
    assign is_beq    = is_branch && (instr_q[14:12] == 3'b000);
    assign is_bge    = is_branch && (instr_q[14:12] == 3'b101);
    assign is_legal  = is_rtype || is_addi || is_ld || is_sd || is_beq || is_bge;

    assign unused_instr_bits = ^{instr_q[31], instr_q[29:15], instr_q[11:7]};

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instruction;
                    state_d = DECODE;
                end
            end
            DECODE:    state_d = is_legal ? EXECUTE : IDLE;
            EXECUTE: begin
                if (is_branch)          state_d = IDLE;
                else if (is_ld || is_sd) state_d = MEMORY;
                else                     state_d = WRITEBACK;
            end
            MEMORY:    state_d = is_ld ? WRITEBACK : IDLE;
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        instr_ready  = (state_q == IDLE);
        ALUOp        = 2'b00;
        Funct        = 4'b0000;
        alu_src      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        branch_taken = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            DECODE: illegal = !is_legal;
            EXECUTE: begin
                if (is_rtype) begin
                    ALUOp = 2'b10;
                    Funct = {instr_q[30], instr_q[14:12]};
                end else if (is_branch) begin
                    ALUOp        = 2'b01;
                    Funct        = {1'b0, instr_q[14:12]};
                    branch_taken = is_beq ? zero : !negative;
                    done         = 1'b1;
                end
                alu_src = is_addi || is_ld || is_sd;
            end
            MEMORY: begin
                mem_read  = is_ld;
                mem_write = is_sd;
                done      = is_sd;
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef CTRL_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    assign retired_d = retired_q + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    retired_q <= 32'd0;
        else if (done) retired_q <= retired_d;
    end

    assign retired_count = retired_q;
`else
    assign retired_count = 32'd0;
`endif

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have port instr_valid, input, 1, instruction offered by fetch.
REQ-004 SHALL have port instruction, input, 32, RV32 instruction word.
REQ-005 SHALL have port zero, input, 1, ALU result-equals-zero flag, valid in EXECUTE.
REQ-006 SHALL have port negative, input, 1, ALU signed-result-negative flag, valid in EXECUTE.
REQ-007 SHALL have port instr_ready, output, 1, block can accept an instruction.
REQ-008 SHALL have port ALUOp, output, 2, ALU class for the ALU control decoder.
REQ-009 SHALL have port Funct, output, 4, function code for the ALU control decoder.
REQ-010 SHALL have ports alu_src, mem_read, mem_write, mem_to_reg, reg_write, output, 1 each, datapath controls.
REQ-011 SHALL have ports branch_taken, done, illegal, output, 1 each, single-cycle status pulses.
REQ-012 SHALL have port retired_count, output, 32, retired-instruction count.

Function
REQ-013 SHALL implement states IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK.
REQ-014 SHALL assert instr_ready only in IDLE; a transfer occurs when instr_valid and instr_ready are both high at a rising edge.
REQ-015 On transfer SHALL latch instruction and move to DECODE; instr_valid outside IDLE is ignored.
REQ-016 SHALL support opcodes: 0110011 R-type, 0010011 addi, 0000011 ld, 0100011 sd, 1100011 branch (funct3 000 beq, 101 bge).
REQ-017 DECODE: unsupported opcode or branch funct3 SHALL pulse illegal for one cycle and return to IDLE; otherwise go to EXECUTE.
REQ-018 In EXECUTE ALUOp SHALL be 10 for R-type, 01 for branch, 00 for addi/ld/sd; 00 in all other states.
REQ-019 In EXECUTE Funct SHALL be {instr[30], instr[14:12]} for R-type, {0, instr[14:12]} for branch, 0000 otherwise; 0000 in all other states.
REQ-020 alu_src SHALL be 1 in EXECUTE for addi/ld/sd, else 0.
REQ-021 Branch in EXECUTE: branch_taken = zero for beq, ~negative for bge; done pulses; next state IDLE.
REQ-022 ld/sd go EXECUTE->MEMORY; R-type/addi go EXECUTE->WRITEBACK.
REQ-023 MEMORY: sd asserts mem_write, pulses done, returns IDLE; ld asserts mem_read, goes to WRITEBACK.
REQ-024 WRITEBACK: reg_write=1, mem_to_reg=1 for ld else 0, done pulses, returns IDLE.
REQ-025 Latency from transfer edge to done: branch 2 cycles, R-type/addi/sd 3, ld 4; illegal pulses 1 cycle after transfer.
REQ-026 done and illegal SHALL never assert in the same cycle; each pulse lasts exactly one cycle.
REQ-027 All controls SHALL be decoded from the current state and latched instruction only, never from the live instruction port.

Reset
REQ-028 reset low SHALL immediately force IDLE; all outputs except instr_ready 0, latched instruction 0, retired_count 0.
REQ-029 Reset mid-instruction SHALL abort it without done, mem_write or reg_write; instr_ready is 1 in the first cycle after release.

Configuration
REQ-030 Macro CTRL_RETIRE_COUNT_EN defined: retired_count SHALL increment by 1 (mod 2^32, wrapping 0xFFFFFFFF->0) on each done pulse; illegal does not count.
REQ-031 CTRL_RETIRE_COUNT_EN undefined: retired_count SHALL be constant 0 and no counter register exists.

Verification
REQ-032 0x002081B3 (add) -> ALUOp=10, Funct=0000 in EXECUTE; reg_write=1 with done 3 cycles after transfer.
REQ-033 0x0020B023 (sd) -> ALUOp=00, alu_src=1, then mem_write=1 with done 3 cycles after transfer, reg_write never 1.
REQ-034 0x0020D063 (bge), negative=0 -> ALUOp=01, Funct=0101, branch_taken=1 and done 2 cycles after transfer; repeat with negative=1 -> branch_taken=0.
REQ-035 0xFFFFFFFF -> illegal pulse 1 cycle after transfer, no done, instr_ready 1 next cycle, retired_count unchanged.
REQ-036 ld 0x0000B183, reset low during MEMORY -> immediate IDLE, no reg_write; next add completes normally.
REQ-037 With CTRL_RETIRE_COUNT_EN, counter preloaded to 0xFFFFFFFF by force, one add -> retired_count=0x00000000.
